instr_cfg_arbiter: RTL

Round-robin arbiter that shares the single 32-bit instruction-packet write port of the instruction configuration path between several packet sources, such as the host loader and BFT leaf ports. Each source may send a multi-packet burst, and a granted source keeps the port until its burst ends. The arbiter registers the winning packet onto `out_wr_en`/`out_packet`, which drive the `instr_wr_en_in`/`instr_packet` inputs of the instruction configuration block. Downstream almost-full backpressure gates all acceptance.

---
 rtl/instr_cfg_pkg.sv | 19 +
 rtl/instr_cfg_rr_pick.sv | 30 +++
 rtl/instr_cfg_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/instr_cfg_pkg.sv
// Shared types and constants for the instruction configuration write path.
// Packets are {addr, data} and pass through the arbiter without modification.
package instr_cfg_pkg;

  localparam int unsigned INSTR_PKT_W  = 32;
  localparam int unsigned INSTR_ADDR_W = 24;
  localparam int unsigned INSTR_DATA_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_XFER
  } arb_state_e;

  typedef struct packed {
    logic [INSTR_ADDR_W-1:0] addr;
    logic [INSTR_DATA_W-1:0] data;
  } instr_pkt_t;

endpackage

// File: rtl/instr_cfg_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request found
// scanning upward from ptr+1, wrapping modulo NUM_REQ.
module instr_cfg_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    // The pointer itself is visited last, so the previous owner has lowest priority.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IdxW'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_cfg_arbiter.sv
// Round-robin burst arbiter feeding the single instruction-packet write port.
// A grant holds until last beat, burst cap, or idle timeout; output is registered.
module instr_cfg_arbiter
  import instr_cfg_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned BURST_MAX   = 8,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INSTR_PKT_W-1:0] req_packet,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           out_afull,
  output logic                           out_wr_en,
  output logic [INSTR_PKT_W-1:0]         out_packet,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned BeatW = $clog2(BURST_MAX) + 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYC) + 1;

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic            wr_en_q, wr_en_d;
  logic            timeout_q, timeout_d;
  instr_pkt_t      pkt_q, pkt_d;

  instr_pkt_t      grant_pkt;
  logic            grant_valid;
  logic            grant_last;
  logic            accept;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;

  instr_cfg_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    grant_pkt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IdxW'(i)) begin
        grant_pkt = req_packet[i*INSTR_PKT_W +: INSTR_PKT_W];
      end
    end
  end

  assign grant_valid = req_valid[grant_q];
  assign grant_last  = req_last[grant_q];
  // afull leaves exactly one slot, which the registered output stage may still fill.
  assign accept      = (state_q == ST_XFER) && grant_valid && !out_afull;

  always_comb begin
    req_ready = '0;
    if (state_q == ST_XFER) begin
      req_ready[grant_q] = !out_afull;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    beat_d    = beat_q;
    idle_d    = idle_q;
    timeout_d = 1'b0;
    wr_en_d   = accept;
    pkt_d     = accept ? grant_pkt : pkt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          beat_d  = '0;
          idle_d  = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (grant_valid) begin
          idle_d = '0;
        end else if (idle_q == IdleW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          rr_ptr_d  = grant_q;
          state_d   = ST_IDLE;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end

        // Last flag and burst cap on the same beat collapse into one release.
        if (accept) begin
          beat_d = beat_q + BeatW'(1);
          if (grant_last || (beat_q == BeatW'(BURST_MAX - 1))) begin
            rr_ptr_d = grant_q;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= IdxW'(NUM_REQ - 1);
      beat_q    <= '0;
      idle_q    <= '0;
      wr_en_q   <= 1'b0;
      timeout_q <= 1'b0;
      pkt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      beat_q    <= beat_d;
      idle_q    <= idle_d;
      wr_en_q   <= wr_en_d;
      timeout_q <= timeout_d;
      pkt_q     <= pkt_d;
    end
  end

  assign out_wr_en   = wr_en_q;
  assign out_packet  = pkt_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q == ST_XFER);
  assign timeout_err = timeout_q;

endmodule
